// File: rtl/serial_subtractor.sv
// serial_subtractor: bit-serial ripple subtractor, LSB first.
// One full-subtractor cell plus a borrow flip-flop computes Diff = A - B - Bin
// over WIDTH clock cycles, with a start/busy/done handshake.
// Optional feature macro: SERIAL_SUB_OVF_EN (signed overflow flag on Ovf).
// When the macro is undefined, Ovf is tied low and no overflow logic exists.
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] Diff,
  output logic             Bout,
  output logic             Ovf
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  state_t           r_state;
  state_t           w_state_next;
  logic             w_accept;
  logic             w_last;
  logic             w_d;
  logic             w_borrow_next;
  logic [WIDTH-1:0] w_res_next;

  logic [WIDTH-1:0] r_a_sh;
  logic [WIDTH-1:0] r_b_sh;
  logic [WIDTH-1:0] r_res;
  logic             r_borrow;
  logic [CW-1:0]    r_cnt;
  logic             r_busy;
  logic             r_done;
  logic [WIDTH-1:0] r_diff;
  logic             r_bout;

  // Full-subtractor cell on the current LSBs of the operand shift registers.
  always_comb begin
    w_d           = r_a_sh[0] ^ r_b_sh[0] ^ r_borrow;
    w_borrow_next = (~r_a_sh[0] & r_b_sh[0]) | (~(r_a_sh[0] ^ r_b_sh[0]) & r_borrow);
    w_res_next    = {w_d, r_res[WIDTH-1:1]};
  end

  // Next-state logic: accept a request in IDLE, leave RUN after the last bit.
  always_comb begin
    w_state_next = r_state;
    w_accept     = 1'b0;
    w_last       = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_state_next = S_RUN;
          w_accept     = 1'b1;
        end else begin
          w_state_next = S_IDLE;
        end
      end
      S_RUN: begin
        if (r_cnt == LAST_CNT) begin
          w_state_next = S_IDLE;
          w_last       = 1'b1;
        end else begin
          w_state_next = S_RUN;
        end
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Datapath: operand capture, one bit per cycle, result publish on the last bit.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_a_sh   <= {WIDTH{1'b0}};
      r_b_sh   <= {WIDTH{1'b0}};
      r_res    <= {WIDTH{1'b0}};
      r_borrow <= 1'b0;
      r_cnt    <= {CW{1'b0}};
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_diff   <= {WIDTH{1'b0}};
      r_bout   <= 1'b0;
    end else if (w_accept) begin
      r_a_sh   <= A;
      r_b_sh   <= B;
      r_res    <= {WIDTH{1'b0}};
      r_borrow <= Bin;
      r_cnt    <= {CW{1'b0}};
      r_busy   <= 1'b1;
      r_done   <= 1'b0;
    end else if (r_state == S_RUN) begin
      r_a_sh   <= {1'b0, r_a_sh[WIDTH-1:1]};
      r_b_sh   <= {1'b0, r_b_sh[WIDTH-1:1]};
      r_res    <= w_res_next;
      r_borrow <= w_borrow_next;
      r_cnt    <= r_cnt + CNT_ONE;
      if (w_last) begin
        // The final bit is folded in directly so Diff never shows a partial word.
        r_diff <= w_res_next;
        r_bout <= w_borrow_next;
        r_done <= 1'b1;
        r_busy <= 1'b0;
      end else begin
        r_done <= 1'b0;
      end
    end else begin
      r_done <= 1'b0;
    end
  end

`ifdef SERIAL_SUB_OVF_EN
  logic r_a_msb;
  logic r_b_msb;
  logic r_ovf;

  // Signed overflow: operand MSBs are kept from acceptance, flag published with Diff.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_a_msb <= 1'b0;
      r_b_msb <= 1'b0;
      r_ovf   <= 1'b0;
    end else if (w_accept) begin
      r_a_msb <= A[WIDTH-1];
      r_b_msb <= B[WIDTH-1];
    end else if (w_last) begin
      r_ovf <= (r_a_msb ^ r_b_msb) & (r_a_msb ^ w_d);
    end else begin
      r_ovf <= r_ovf;
    end
  end

  assign Ovf = r_ovf;
`else
  assign Ovf = 1'b0;
`endif

  assign busy = r_busy;
  assign done = r_done;
  assign Diff = r_diff;
  assign Bout = r_bout;

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor (WIDTH=8): directed scenarios plus
// a randomized sweep checked against an arithmetic reference model.
module tb_serial_subtractor;

  localparam int W = 8;

  logic         clk;
  logic         rst;
  logic         start;
  logic [W-1:0] A;
  logic [W-1:0] B;
  logic         Bin;
  logic         busy;
  logic         done;
  logic [W-1:0] Diff;
  logic         Bout;
  logic         Ovf;

  int n_cmp;
  int n_err;

  serial_subtractor #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .A     (A),
    .B     (B),
    .Bin   (Bin),
    .busy  (busy),
    .done  (done),
    .Diff  (Diff),
    .Bout  (Bout),
    .Ovf   (Ovf)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference model: plain arithmetic on the operands.
  function automatic logic [W:0] model_sub(input logic [W-1:0] a, input logic [W-1:0] b,
                                            input logic bin);
    logic [W:0] full;
    full = {1'b0, a} - {1'b0, b} - {{W{1'b0}}, bin};
    return full;
  endfunction

  function automatic logic model_ovf(input logic [W-1:0] a, input logic [W-1:0] b,
                                     input logic bin);
`ifdef SERIAL_SUB_OVF_EN
    int sa;
    int sb;
    int ib;
    int r;
    sa = int'($signed(a));
    sb = int'($signed(b));
    ib = int'(bin);
    r  = sa - sb - ib;
    return (r > 127) || (r < -128);
`else
    return 1'b0;
`endif
  endfunction

  // Drive a request now (caller sits just after a rising edge) and wait for done.
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic bin,
                        output logic [W-1:0] diff, output logic bout, output logic ovf,
                        output int lat, output int busy_cyc, output bit to);
    A = a; B = b; Bin = bin; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    busy_cyc = busy ? 1 : 0;
    lat = 0;
    to = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      lat++;
      if (done) begin
        to = 1'b0;
        break;
      end else if (busy) begin
        busy_cyc++;
      end
    end
    diff = Diff; bout = Bout; ovf = Ovf;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; A = 8'h00; B = 8'h00; Bin = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_cmp++;
    if ({busy, done, Diff, Bout, Ovf} !== {1'b0, 1'b0, 8'h00, 1'b0, 1'b0}) begin
      n_err++;
      $display("FAIL reset_state: got busy=%b done=%b Diff=%h Bout=%b Ovf=%b, want all zero",
               busy, done, Diff, Bout, Ovf);
    end
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic check_op(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic bin, input logic [W-1:0] want_diff, input logic want_bout);
    logic [W-1:0] diff;
    logic         bout;
    logic         ovf;
    int           lat;
    int           bc;
    bit           to;
    logic [W:0]   m;
    run_op(a, b, bin, diff, bout, ovf, lat, bc, to);
    m = model_sub(a, b, bin);
    n_cmp++;
    if (to || lat != W) begin
      n_err++;
      $display("FAIL %s_latency: got %0d (timeout=%0d), want %0d", name, lat, to, W);
    end
    n_cmp++;
    if ({bout, diff} !== {want_bout, want_diff} || {bout, diff} !== m) begin
      n_err++;
      $display("FAIL %s_result: got Bout=%b Diff=%h, want Bout=%b Diff=%h",
               name, bout, diff, want_bout, want_diff);
    end
    n_cmp++;
    if (ovf !== model_ovf(a, b, bin)) begin
      n_err++;
      $display("FAIL %s_ovf: got %b, want %b", name, ovf, model_ovf(a, b, bin));
    end
    n_cmp++;
    if (bc != W) begin
      n_err++;
      $display("FAIL %s_busy_cycles: got %0d, want %0d", name, bc, W);
    end
  endtask

  task automatic test_basic();
    check_op("basic", 8'h25, 8'h13, 1'b0, 8'h12, 1'b0);
    @(posedge clk); #1;
    n_cmp++;
    if (done !== 1'b0 || Diff !== 8'h12) begin
      n_err++;
      $display("FAIL basic_done_pulse: got done=%b Diff=%h, want done=0 Diff=12", done, Diff);
    end
  endtask

  task automatic test_underflow();
    check_op("underflow", 8'h00, 8'h01, 1'b1, 8'hFE, 1'b1);
  endtask

  task automatic test_signed_overflow();
    check_op("sovf", 8'h80, 8'h01, 1'b0, 8'h7F, 1'b0);
  endtask

  task automatic test_reset_mid();
    bit seen;
    A = 8'h55; B = 8'h0A; Bin = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
    end
    rst = 1'b1;
    @(posedge clk); #1;
    n_cmp++;
    if ({busy, done, Diff, Bout, Ovf} !== {1'b0, 1'b0, 8'h00, 1'b0, 1'b0}) begin
      n_err++;
      $display("FAIL reset_mid_state: got busy=%b done=%b Diff=%h Bout=%b Ovf=%b, want all zero",
               busy, done, Diff, Bout, Ovf);
    end
    rst = 1'b0;
    seen = 1'b0;
    repeat (12) begin
      @(posedge clk); #1;
      if (done) seen = 1'b1;
    end
    n_cmp++;
    if (seen !== 1'b0) begin
      n_err++;
      $display("FAIL reset_mid_no_done: got done pulse, want none");
    end
    check_op("reset_mid_restart", 8'h55, 8'h0A, 1'b0, 8'h4B, 1'b0);
  endtask

  task automatic test_handshake();
    int lat;
    bit to;
    A = 8'h37; B = 8'h11; Bin = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    A = 8'hAA;
    lat = 0;
    to = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      lat++;
      if (lat == 3) begin
        start = 1'b1;
        B = 8'h01;
      end else begin
        start = 1'b0;
      end
      if (done) begin
        to = 1'b0;
        break;
      end
    end
    n_cmp++;
    if (to || lat != W) begin
      n_err++;
      $display("FAIL handshake_latency: got %0d (timeout=%0d), want %0d", lat, to, W);
    end
    n_cmp++;
    if ({Bout, Diff} !== model_sub(8'h37, 8'h11, 1'b0)) begin
      n_err++;
      $display("FAIL handshake_capture: got Bout=%b Diff=%h, want Bout=0 Diff=26", Bout, Diff);
    end
    // Still in the done cycle: this request must be accepted.
    check_op("handshake_b2b", 8'hFF, 8'hFF, 1'b0, 8'h00, 1'b0);
  endtask

  task automatic test_random();
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         bin;
    logic [W-1:0] diff;
    logic         bout;
    logic         ovf;
    logic [W:0]   m;
    int           lat;
    int           bc;
    bit           to;
    for (int n = 0; n < 500; n++) begin
      a   = W'($urandom);
      b   = W'($urandom);
      bin = 1'($urandom);
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk); #1;
      end
      run_op(a, b, bin, diff, bout, ovf, lat, bc, to);
      m = model_sub(a, b, bin);
      n_cmp++;
      if (to || lat != W) begin
        n_err++;
        $display("FAIL rand_latency[%0d]: got %0d (timeout=%0d), want %0d", n, lat, to, W);
      end
      n_cmp++;
      if ({bout, diff} !== m) begin
        n_err++;
        $display("FAIL rand_result[%0d]: A=%h B=%h Bin=%b got %b_%h, want %b_%h",
                 n, a, b, bin, bout, diff, m[W], m[W-1:0]);
      end
      n_cmp++;
      if (ovf !== model_ovf(a, b, bin)) begin
        n_err++;
        $display("FAIL rand_ovf[%0d]: A=%h B=%h Bin=%b got %b, want %b",
                 n, a, b, bin, ovf, model_ovf(a, b, bin));
      end
    end
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst = 1'b1; start = 1'b0; A = 8'h00; B = 8'h00; Bin = 1'b0;
    test_reset();
    test_basic();
    test_underflow();
    test_signed_overflow();
    test_reset_mid();
    test_handshake();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
